// File: rtl/cache_mem_pkg.sv
// ============================================================================
// cache_mem_pkg: shared FSM encoding, geometry helpers and parameter checks
// Rev 1.0
// ============================================================================
`default_nettype none

package cache_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WB     = 3'd2,
    S_FILL   = 3'd3,
    S_RESP   = 3'd4,
    S_FLUSH  = 3'd5
  } state_t;

  localparam int C_DEF_INDEX_W     = 4;
  localparam int C_DEF_MEM_DEPTH_W = 12;

  function automatic int tag_width(input int mem_depth_w, input int index_w);
    return mem_depth_w - index_w;
  endfunction

  function automatic bit params_ok(input int addr_w, input int index_w,
                                   input int mem_depth_w, input int mem_latency);
    return (index_w > 0) && (index_w < mem_depth_w) &&
           (mem_depth_w <= addr_w) && (mem_latency >= 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_mem_wb_backing_ram.sv
// ============================================================================
// backing_ram: single-port word RAM, each access occupies LATENCY cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module backing_ram #(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] o_rdata
);

  localparam int C_CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  logic [DW-1:0]   r_mem [2**AW];
  logic            r_busy;
  logic [C_CW-1:0] r_cnt;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;

  logic            w_done;
  logic            w_we;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;

  // The start cycle is the first access cycle; single-cycle accesses complete
  // straight from the request inputs.
  assign w_done  = (r_busy && (r_cnt == '0)) || (i_start && (LATENCY == 1));
  assign w_we    = r_busy ? r_we    : i_we;
  assign w_addr  = r_busy ? r_addr  : i_addr;
  assign w_wdata = r_busy ? r_wdata : i_wdata;

  assign o_busy  = r_busy;
  assign o_done  = w_done;
  assign o_rdata = r_mem[w_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_start && !r_busy && (LATENCY > 1)) begin
      r_busy  <= 1'b1;
      r_cnt   <= C_CW'(LATENCY - 2);
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else if (r_busy) begin
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_done && w_we) r_mem[w_addr] <= w_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/cache_mem_wb.sv
// ============================================================================
// cache_mem_wb: direct-mapped write-back, write-allocate cache with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module cache_mem_wb
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int INDEX_W     = C_DEF_INDEX_W,
  parameter int MEM_DEPTH_W = C_DEF_MEM_DEPTH_W,
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int C_LINES = 2**INDEX_W;
  localparam int C_TAG_W = tag_width(MEM_DEPTH_W, INDEX_W);

  if (!params_ok(ADDR_W, INDEX_W, MEM_DEPTH_W, MEM_LATENCY)) begin : g_bad_params
    $error("cache_mem_wb: illegal geometry or latency parameters");
  end

  if (ADDR_W > MEM_DEPTH_W) begin : g_addr_alias
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^req_addr[ADDR_W-1:MEM_DEPTH_W];
  end

  state_t                 r_state, w_next;
  logic                   r_ready;
  logic                   r_write;
  logic [MEM_DEPTH_W-1:0] r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic                   r_hit;
  logic [INDEX_W-1:0]     r_fidx;
  logic [C_LINES-1:0]     r_valid, r_dirty;
  logic [C_TAG_W-1:0]     r_tag  [C_LINES];
  logic [DATA_W-1:0]      r_data [C_LINES];
  logic [CNT_W-1:0]       r_hit_cnt, r_miss_cnt;
  logic                   r_resp_valid, r_resp_hit, r_flush_done;
  logic [DATA_W-1:0]      r_resp_rdata;

  logic [INDEX_W-1:0]     w_idx;
  logic [C_TAG_W-1:0]     w_tag;
  logic                   w_lookup_hit, w_fdirty, w_flush_step, w_accept;
  logic                   w_ram_start, w_ram_we, w_ram_busy, w_ram_done;
  logic [MEM_DEPTH_W-1:0] w_ram_addr;
  logic [DATA_W-1:0]      w_ram_wdata, w_ram_rdata;

  assign w_idx        = r_addr[INDEX_W-1:0];
  assign w_tag        = r_addr[MEM_DEPTH_W-1:INDEX_W];
  assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fdirty     = r_valid[r_fidx] && r_dirty[r_fidx];

  // A flush request in IDLE wins over a simultaneous request.
  assign req_ready  = r_ready && !flush_req;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_hit   = r_resp_hit;
  assign flush_done = r_flush_done;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_flush_step = 1'b0;
    w_ram_start  = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_addr   = r_addr;
    w_ram_wdata  = r_data[w_idx];
    case (r_state)
      S_IDLE: begin
        if (flush_req) begin
          w_next = S_FLUSH;
        end else if (req_valid && req_ready) begin
          w_accept = 1'b1;
          w_next   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_lookup_hit)                      w_next = S_RESP;
        else if (r_valid[w_idx] && r_dirty[w_idx]) w_next = S_WB;
        else                                   w_next = S_FILL;
      end
      S_WB: begin
        w_ram_start = !w_ram_busy;
        w_ram_we    = 1'b1;
        w_ram_addr  = {r_tag[w_idx], w_idx};
        if (w_ram_done) w_next = S_FILL;
      end
      S_FILL: begin
        w_ram_start = !w_ram_busy;
        if (w_ram_done) w_next = S_RESP;
      end
      S_RESP: w_next = S_IDLE;
      S_FLUSH: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = {r_tag[r_fidx], r_fidx};
        w_ram_wdata = r_data[r_fidx];
        if (w_fdirty) begin
          w_ram_start  = !w_ram_busy;
          w_flush_step = w_ram_done;
        end else begin
          w_flush_step = 1'b1;
        end
        if (w_flush_step && (&r_fidx)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b1;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_hit        <= 1'b0;
      r_fidx       <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_hit   <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      // Ready stays low for the cycle carrying resp_valid.
      r_ready      <= (w_next == S_IDLE) && (r_state != S_RESP);
      r_resp_valid <= (r_state == S_RESP);
      r_flush_done <= (r_state == S_FLUSH) && (w_next == S_IDLE);
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr[MEM_DEPTH_W-1:0];
        r_wdata <= req_wdata;
      end
      case (r_state)
        S_LOOKUP: begin
          r_hit <= w_lookup_hit;
          if (w_lookup_hit) begin
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
          end else begin
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
          end
        end
        S_FILL: begin
          if (w_ram_done) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
          end
        end
        S_RESP: begin
          r_resp_rdata <= r_write ? r_wdata : r_data[w_idx];
          r_resp_hit   <= r_hit;
          if (r_write) r_dirty[w_idx] <= 1'b1;
        end
        S_FLUSH: begin
          if (w_flush_step) begin
            if (&r_fidx) begin
              r_valid <= '0;
              r_dirty <= '0;
              r_fidx  <= '0;
            end else begin
              r_fidx <= r_fidx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_FILL) && w_ram_done) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= w_ram_rdata;
    end else if ((r_state == S_RESP) && r_write) begin
      r_data[w_idx] <= r_wdata;
    end
  end

  backing_ram #(
    .AW      (MEM_DEPTH_W),
    .DW      (DATA_W),
    .LATENCY (MEM_LATENCY)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_ram_start),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_busy  (w_ram_busy),
    .o_done  (w_ram_done),
    .o_rdata (w_ram_rdata)
  );

endmodule

`default_nettype wire
